seven_seg_scanner: RTL and testbench

- Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one hex-to-segment decoder.
- Holds a displayed value, selects one digit per slot and presents that digit's nibble to the shared decoder.
- Drives active-low anode and decimal-point lines, with a blanking gap between digits to suppress ghosting.
- Sits between the counter/datapath producing the value and the decoder feeding the segment pins; new values are accepted only at frame boundaries, so the display never tears.

---
 rtl/seven_seg_scanner.sv | 230 +++++++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed scan controller for a bank of common-anode seven-segment
// digits that share one hex-to-segment decoder. Each digit slot is a BLANK
// period (all anodes off, decoder input settles) followed by a DRIVE period
// (one anode on). New display data is staged in a pending register and only
// copied into the shadow (displayed) register at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS   number of digits (2..8), digit NUM_DIGITS-1 is most significant
//   ON_CYCLES    clocks each anode is driven per slot (>=1)
//   BLANK_CYCLES clocks all anodes are off before each digit (>=1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   load        one-cycle strobe capturing value_in / dp_in as pending data
//   value_in    nibble i (bits 4i+3:4i) is digit i
//   dp_in       decimal point per digit, 1 = lit
//   dig_out     nibble presented to the shared decoder
//   an_n        active-low anode enables (one-hot-low or all ones)
//   dp_n        active-low decimal point
//   frame_done  one-cycle pulse at the start of each new scan
//   load_ack    one-cycle pulse when pending data enters the shadow register
//
// Build option:
//   LEADING_ZERO_SUPPRESS_EN  when defined, leading zero digits (i>0) with no
//                             decimal point keep their anode off during DRIVE.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              dig_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_done,
    output logic                    load_ack
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [4*NUM_DIGITS-1:0] pending_r;
    logic [NUM_DIGITS-1:0]   pending_dp_r;
    logic                    pending_vld_r;

    state_t                  state_s;
    logic [IDX_W-1:0]        idx_s;
    logic [CNT_W-1:0]        cnt_s;
    logic [4*NUM_DIGITS-1:0] shadow_s;
    logic [NUM_DIGITS-1:0]   shadow_dp_s;
    logic                    pending_vld_s;
    logic                    boundary_s;
    logic                    suppress_s;
    logic [NUM_DIGITS-1:0]   an_n_s;
    logic                    dp_n_s;
    logic [3:0]              dig_out_s;

`ifdef LEADING_ZERO_SUPPRESS_EN
    // A digit is a leading zero when it and every more significant nibble are
    // zero and it carries no decimal point; digit 0 always shows.
    function automatic logic lead_zero(
        input logic [4*NUM_DIGITS-1:0] v,
        input logic [NUM_DIGITS-1:0]   dp,
        input logic [IDX_W-1:0]        i
    );
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(i)) && (v[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end else begin
                upper_zero = upper_zero;
            end
        end
        return (i != '0) && upper_zero && !dp[i];
    endfunction
`endif

    // Next-state, next-data and next-output computation for the scan FSM.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        cnt_s         = cnt_r;
        shadow_s      = shadow_r;
        shadow_dp_s   = shadow_dp_r;
        pending_vld_s = pending_vld_r;
        boundary_s    = 1'b0;

        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = ST_DRIVE;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_r == ON_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = '0;
                    if (idx_r == LAST_IDX) begin
                        idx_s      = '0;
                        boundary_s = 1'b1;
                    end else begin
                        idx_s      = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_BLANK;
                idx_s   = '0;
                cnt_s   = '0;
            end
        endcase

        // At the boundary a same-cycle load bypasses the pending register.
        if (boundary_s) begin
            if (load) begin
                shadow_s    = value_in;
                shadow_dp_s = dp_in;
            end else if (pending_vld_r) begin
                shadow_s    = pending_r;
                shadow_dp_s = pending_dp_r;
            end else begin
                shadow_s    = shadow_r;
                shadow_dp_s = shadow_dp_r;
            end
            pending_vld_s = 1'b0;
        end else if (load) begin
            pending_vld_s = 1'b1;
        end else begin
            pending_vld_s = pending_vld_r;
        end

`ifdef LEADING_ZERO_SUPPRESS_EN
        suppress_s = lead_zero(shadow_s, shadow_dp_s, idx_s);
`else
        suppress_s = 1'b0;
`endif

        // Outputs are derived from the state being entered so they register
        // in step with it.
        if ((state_s == ST_DRIVE) && !suppress_s) begin
            an_n_s = ~(NUM_DIGITS'(1) << idx_s);
        end else begin
            an_n_s = {NUM_DIGITS{1'b1}};
        end

        if (state_s == ST_DRIVE) begin
            dp_n_s = ~shadow_dp_s[idx_s];
        end else begin
            dp_n_s = 1'b1;
        end

        // The decoder input only moves on entry to BLANK, giving it the whole
        // blanking gap to settle before an anode turns on.
        if (state_s == ST_BLANK) begin
            dig_out_s = shadow_s[{idx_s, 2'b00} +: 4];
        end else begin
            dig_out_s = dig_out;
        end
    end

    // Scan FSM, data registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_BLANK;
            idx_r         <= '0;
            cnt_r         <= '0;
            shadow_r      <= '0;
            shadow_dp_r   <= '0;
            pending_r     <= '0;
            pending_dp_r  <= '0;
            pending_vld_r <= 1'b0;
            dig_out       <= 4'h0;
            an_n          <= {NUM_DIGITS{1'b1}};
            dp_n          <= 1'b1;
            frame_done    <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            cnt_r         <= cnt_s;
            shadow_r      <= shadow_s;
            shadow_dp_r   <= shadow_dp_s;
            pending_vld_r <= pending_vld_s;
            if (load) begin
                pending_r    <= value_in;
                pending_dp_r <= dp_in;
            end else begin
                pending_r    <= pending_r;
                pending_dp_r <= pending_dp_r;
            end
            dig_out       <= dig_out_s;
            an_n          <= an_n_s;
            dp_n          <= dp_n_s;
            frame_done    <= boundary_s;
            load_ack      <= boundary_s && (load || pending_vld_r);
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// Testbench for seven_seg_scanner with NUM_DIGITS=4, BLANK_CYCLES=2,
// ON_CYCLES=4 (24-clock frame). A frame-position reference model predicts
// every output on every clock; directed steps cover reset, scan order,
// tear-free updates, load collisions, mid-frame reset and (when built with
// LEADING_ZERO_SUPPRESS_EN) leading zero suppression, then random loads.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int N     = 4;
    localparam int BLK   = 2;
    localparam int ON    = 4;
    localparam int SLOT  = BLK + ON;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  dig_out;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_done;
    logic        load_ack;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position within the frame plus displayed/pending data.
    int          m_t = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [3:0]  m_sdp = 4'h0;
    logic [15:0] m_pend = 16'h0000;
    logic [3:0]  m_pdp = 4'h0;
    logic        m_flag = 1'b0;
    logic        e_fd = 1'b0;
    logic        e_ack = 1'b0;

    localparam logic [3:0] SCAN_AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [3:0] SCAN_DIG [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

    seven_seg_scanner #(
        .NUM_DIGITS  (N),
        .ON_CYCLES   (ON),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .dig_out   (dig_out),
        .an_n      (an_n),
        .dp_n      (dp_n),
        .frame_done(frame_done),
        .load_ack  (load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge with the inputs just applied.
    task automatic model_edge(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
        if (r) begin
            m_t = 0; m_shadow = 16'h0; m_sdp = 4'h0;
            m_pend = 16'h0; m_pdp = 4'h0; m_flag = 1'b0;
            e_fd = 1'b0; e_ack = 1'b0;
        end else begin
            e_fd  = (m_t == FRAME - 1);
            e_ack = e_fd && (ld || m_flag);
            if (e_fd) begin
                if (ld) begin
                    m_shadow = v; m_sdp = d;
                end else if (m_flag) begin
                    m_shadow = m_pend; m_sdp = m_pdp;
                end
                m_flag = 1'b0;
            end else if (ld) begin
                m_pend = v; m_pdp = d; m_flag = 1'b1;
            end
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    task automatic check_outputs();
        int          slot;
        logic        blank;
        logic        supp;
        logic [3:0]  one_hot;
        logic [3:0]  exp_an;
        logic [3:0]  exp_dig;
        logic        exp_dp;
        slot    = m_t / SLOT;
        blank   = (m_t % SLOT) < BLK;
`ifdef LEADING_ZERO_SUPPRESS_EN
        supp    = (slot > 0) && ((m_shadow >> (4 * slot)) == 16'h0) && !m_sdp[slot];
`else
        supp    = 1'b0;
`endif
        one_hot = 4'(4'b0001 << slot);
        exp_an  = (!blank && !supp) ? ~one_hot : 4'hF;
        exp_dp  = blank ? 1'b1 : ~m_sdp[slot];
        exp_dig = 4'(m_shadow >> (4 * slot));
        chk("an_n", 32'(an_n), 32'(exp_an));
        chk("dp_n", 32'(dp_n), 32'(exp_dp));
        chk("dig_out", 32'(dig_out), 32'(exp_dig));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("load_ack", 32'(load_ack), 32'(e_ack));
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
        rst = r; load = ld; value_in = v; dp_in = d;
        @(posedge clk);
        model_edge(r, ld, v, d);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0000, 4'h0);
    endtask

    // Step until the model sits at frame position t (bounded by one frame).
    task automatic run_to(input int t);
        for (int i = 0; i < FRAME && m_t != t; i++) idle();
    endtask

    task automatic wait_ack(input string tag);
        logic seen;
        seen = load_ack;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            idle();
            seen = load_ack;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int   first_fd;
        int   acks;
        logic tore;
        logic fd_seen;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 4'h0);
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_dp_n", 32'(dp_n), 32'd1);
        chk("rst_dig_out", 32'(dig_out), 32'd0);

        // First frame_done exactly one frame after release.
        first_fd = 0;
        for (int i = 1; i <= FRAME + 6; i++) begin
            idle();
            if (first_fd == 0 && frame_done) first_fd = i;
        end
        chk("first_frame_done", 32'(first_fd), 32'(FRAME));

        // Scan order for 1234.
        step(1'b0, 1'b1, 16'h1234, 4'h0);
        wait_ack("ack_1234");
        chk("ack_with_frame_done", 32'(frame_done), 32'd1);
        for (int k = 0; k < N; k++) begin
            run_to(k * SLOT + BLK);
            chk("scan_an", 32'(an_n), 32'(SCAN_AN[k]));
            chk("scan_dig", 32'(dig_out), 32'(SCAN_DIG[k]));
        end

        // No tearing: ABCD loaded mid-frame must wait for the boundary.
        run_to(8);
        step(1'b0, 1'b1, 16'hABCD, 4'h0);
        tore = 1'b0;
        for (int i = 0; i < 2 * FRAME && !load_ack; i++) begin
            if (dig_out >= 4'hA) tore = 1'b1;
            idle();
        end
        chk("no_tear", 32'(tore), 32'd0);
        chk("abcd_ack_frame_done", 32'(frame_done), 32'd1);
        run_to(BLK);
        chk("abcd_dig0", 32'(dig_out), 32'hD);

        // Two loads in one frame: one ack, last value wins.
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        run_to(10);
        step(1'b0, 1'b1, 16'h2222, 4'h0);
        acks = 0;
        fd_seen = 1'b0;
        for (int i = 0; i < FRAME && !fd_seen; i++) begin
            idle();
            if (load_ack) acks++;
            fd_seen = frame_done;
        end
        chk("collision_one_ack", 32'(acks), 32'd1);
        run_to(BLK);
        chk("collision_last_wins", 32'(dig_out), 32'h2);

        // Load on the boundary cycle is acked at that boundary.
        run_to(FRAME - 1);
        step(1'b0, 1'b1, 16'h5678, 4'h0);
        chk("boundary_ack", 32'(load_ack), 32'd1);
        chk("boundary_fd", 32'(frame_done), 32'd1);
        run_to(BLK);
        chk("boundary_dig0", 32'(dig_out), 32'h8);

        // Reset during DRIVE of digit 2 discards a pending load.
        run_to(3);
        step(1'b0, 1'b1, 16'h9999, 4'hF);
        run_to(2 * SLOT + BLK + 1);
        step(1'b1, 1'b0, 16'h0000, 4'h0);
        chk("midrst_an_n", 32'(an_n), 32'hF);
        chk("midrst_dig", 32'(dig_out), 32'd0);
        chk("midrst_dp_n", 32'(dp_n), 32'd1);
        acks = 0;
        for (int i = 0; i < FRAME + 6; i++) begin
            idle();
            if (load_ack) acks++;
        end
        chk("midrst_no_ack", 32'(acks), 32'd0);

        // Leading zeros: 0050 with no decimal points, then with dp on digit 3.
        step(1'b0, 1'b1, 16'h0050, 4'b0000);
        wait_ack("ack_0050");
        run_to(BLK);
        chk("lz_d0_an", 32'(an_n), 32'b1110);
        run_to(SLOT + BLK);
        chk("lz_d1_an", 32'(an_n), 32'b1101);
        run_to(2 * SLOT + BLK);
`ifdef LEADING_ZERO_SUPPRESS_EN
        chk("lz_d2_an", 32'(an_n), 32'b1111);
`else
        chk("lz_d2_an", 32'(an_n), 32'b1011);
`endif
        run_to(3 * SLOT + BLK);
`ifdef LEADING_ZERO_SUPPRESS_EN
        chk("lz_d3_an", 32'(an_n), 32'b1111);
`else
        chk("lz_d3_an", 32'(an_n), 32'b0111);
`endif
        step(1'b0, 1'b1, 16'h0050, 4'b1000);
        wait_ack("ack_0050_dp");
        run_to(3 * SLOT + BLK);
        chk("lz_dp_d3_an", 32'(an_n), 32'b0111);
        chk("lz_dp_d3_dig", 32'(dig_out), 32'h0);
        chk("lz_dp_d3_dp", 32'(dp_n), 32'd0);

        // Random loads and occasional resets against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 16'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
